// File: rtl/core_exec.sv
// Instruction-execution core: valid/ready input queue feeding a single-cycle
// execute stage with an internal register file and {Z,N,C,V} result flags.
module core_exec #(
    parameter  int unsigned DATA_W     = 8,
    parameter  int unsigned REG_N      = 4,
    parameter  int unsigned FIFO_DEPTH = 4,
    localparam int unsigned RA         = $clog2(REG_N),
    localparam int unsigned INST_W     = 3 + 2 * RA + DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rsn,
    input  logic [INST_W-1:0] i_inst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_hold,
    output logic              o_res_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [3:0]        o_flag,
    output logic              o_busy
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_LDI = 3'd1,
        OP_ADD = 3'd2,
        OP_SUB = 3'd3,
        OP_AND = 3'd4,
        OP_OR  = 3'd5,
        OP_XOR = 3'd6,
        OP_OUT = 3'd7
    } op_e;

    // Input queue state
    logic [INST_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              push;
    logic              pop;

    // Execute stage state
    logic [INST_W-1:0] ex_inst;
    logic              ex_valid;
    logic [DATA_W-1:0] rf [REG_N];

    // Execute stage decode and datapath
    op_e               ex_op;
    logic [RA-1:0]     ex_dst;
    logic [RA-1:0]     ex_src;
    logic [DATA_W-1:0] ex_imm;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic [DATA_W:0]   sum_ext;
    logic [DATA_W:0]   diff_ext;
    logic [DATA_W-1:0] res;
    logic              c_flag;
    logic              v_flag;
    logic              wr_en;
    logic              res_en;

    assign o_ready = (count < CW'(FIFO_DEPTH));
    assign o_busy  = (count != '0) || ex_valid;
    assign push    = i_valid && o_ready;
    assign pop     = (count != '0) && !i_hold;

    // Queue storage carries no reset; occupancy is tracked by count
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_inst;
        end
    end

    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Execute register: loaded on every pop, bubbles otherwise
    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            ex_inst  <= '0;
            ex_valid <= 1'b0;
        end else begin
            ex_valid <= pop;
            if (pop) begin
                ex_inst <= mem[rd_ptr];
            end
        end
    end

    assign ex_op    = op_e'(ex_inst[INST_W-1 -: 3]);
    assign ex_dst   = ex_inst[INST_W-4 -: RA];
    assign ex_src   = ex_inst[DATA_W +: RA];
    assign ex_imm   = ex_inst[DATA_W-1:0];
    assign opa      = rf[ex_dst];
    assign opb      = rf[ex_src];
    assign sum_ext  = {1'b0, opa} + {1'b0, opb};
    assign diff_ext = {1'b0, opa} - {1'b0, opb};

    // ALU: result, carry/borrow and signed overflow per opcode
    always_comb begin
        res    = '0;
        c_flag = 1'b0;
        v_flag = 1'b0;
        wr_en  = 1'b0;
        case (ex_op)
            OP_LDI: begin
                res   = ex_imm;
                wr_en = 1'b1;
            end
            OP_ADD: begin
                res    = sum_ext[DATA_W-1:0];
                c_flag = sum_ext[DATA_W];
                v_flag = (opa[DATA_W-1] == opb[DATA_W-1]) && (res[DATA_W-1] != opa[DATA_W-1]);
                wr_en  = 1'b1;
            end
            OP_SUB: begin
                res    = diff_ext[DATA_W-1:0];
                c_flag = diff_ext[DATA_W];
                v_flag = (opa[DATA_W-1] != opb[DATA_W-1]) && (res[DATA_W-1] != opa[DATA_W-1]);
                wr_en  = 1'b1;
            end
            OP_AND: begin
                res   = opa & opb;
                wr_en = 1'b1;
            end
            OP_OR: begin
                res   = opa | opb;
                wr_en = 1'b1;
            end
            OP_XOR: begin
                res   = opa ^ opb;
                wr_en = 1'b1;
            end
            OP_OUT: begin
                res = opb;
            end
            default: begin
                res = '0;
            end
        endcase
    end

    assign res_en = ex_valid && (ex_op != OP_NOP);

    // Register file writeback
    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            for (int unsigned i = 0; i < REG_N; i++) begin
                rf[i] <= '0;
            end
        end else if (ex_valid && wr_en) begin
            rf[ex_dst] <= res;
        end
    end

    // Result outputs hold their value between pulses
    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            o_res_valid <= 1'b0;
            o_data      <= '0;
            o_flag      <= 4'b0000;
        end else begin
            o_res_valid <= res_en;
            if (res_en) begin
                o_data <= res;
                o_flag <= {(res == '0), res[DATA_W-1], c_flag, v_flag};
            end
        end
    end

endmodule

// File: tb/tb_core_exec.sv
// Directed scoreboard bench for core_exec at default parameters:
// stimulus pushes expected results, a negedge monitor pops and compares.
module tb_core_exec;

    typedef struct {
        logic [7:0]  d;
        logic [3:0]  f;
        bit          lat;
        int unsigned cyc;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_rsn;
    logic [14:0] i_inst;
    logic        i_valid;
    logic        o_ready;
    logic        i_hold;
    logic        o_res_valid;
    logic [7:0]  o_data;
    logic [3:0]  o_flag;
    logic        o_busy;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;

    core_exec dut (
        .i_clk       (i_clk),
        .i_rsn       (i_rsn),
        .i_inst      (i_inst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_hold      (i_hold),
        .o_res_valid (o_res_valid),
        .o_data      (o_data),
        .o_flag      (o_flag),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    function automatic logic [14:0] mk(input logic [2:0] op, input logic [1:0] d,
                                       input logic [1:0] s, input logic [7:0] imm);
        return {op, d, s, imm};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Offer one word, wait for acceptance, record its expected result
    task automatic send(input logic [14:0] w, input logic [7:0] ed, input logic [3:0] ef,
                        input bit pulse, input bit lat);
        int n;
        exp_t e;
        n = 0;
        i_inst  = w;
        i_valid = 1'b1;
        while (!o_ready && n < 200) begin
            @(posedge i_clk); #1;
            n++;
        end
        if (!o_ready) begin
            chk("send_timeout", 32'(o_ready), 32'd1);
        end
        @(posedge i_clk); #1;
        if (pulse) begin
            e.d   = ed;
            e.f   = ef;
            e.lat = lat;
            e.cyc = cyc + 2;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        i_valid = 1'b0;
        i_inst  = '0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((o_busy || sb.size() != 0) && n < 200) begin
            @(posedge i_clk); #1;
            n++;
        end
        chk("drain_idle", 32'(o_busy || sb.size() != 0), 32'd0);
    endtask

    // Monitor: every result pulse must match the oldest outstanding expectation
    always @(negedge i_clk) begin
        if (i_rsn && o_res_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got data 0x%0h flag %b expected no pulse", o_data, o_flag);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("res_data", 32'(o_data), 32'(e.d));
                chk("res_flag", 32'(o_flag), 32'(e.f));
                if (e.lat) begin
                    chk("res_latency_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        i_rsn   = 1'b0;
        i_valid = 1'b0;
        i_hold  = 1'b0;
        i_inst  = '0;
        #12;
        chk("rst_res_valid", 32'(o_res_valid), 32'd0);
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_flag", 32'(o_flag), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd1);
        @(negedge i_clk);
        i_rsn = 1'b1;
        @(posedge i_clk); #1;

        // Back-to-back ALU sequences, each result two cycles after acceptance
        send(mk(3'd1, 2'd0, 2'd0, 8'h05), 8'h05, 4'b0000, 1, 1);
        send(mk(3'd1, 2'd1, 2'd0, 8'h03), 8'h03, 4'b0000, 1, 1);
        send(mk(3'd2, 2'd0, 2'd1, 8'h00), 8'h08, 4'b0000, 1, 1);
        send(mk(3'd1, 2'd2, 2'd0, 8'h7F), 8'h7F, 4'b0000, 1, 1);
        send(mk(3'd1, 2'd3, 2'd0, 8'h01), 8'h01, 4'b0000, 1, 1);
        send(mk(3'd2, 2'd2, 2'd3, 8'h00), 8'h80, 4'b0101, 1, 1);
        send(mk(3'd2, 2'd2, 2'd2, 8'h00), 8'h00, 4'b1011, 1, 1);
        send(mk(3'd1, 2'd0, 2'd0, 8'h02), 8'h02, 4'b0000, 1, 1);
        send(mk(3'd1, 2'd1, 2'd0, 8'h05), 8'h05, 4'b0000, 1, 1);
        send(mk(3'd3, 2'd0, 2'd1, 8'h00), 8'hFD, 4'b0110, 1, 1);
        send(mk(3'd3, 2'd1, 2'd1, 8'h00), 8'h00, 4'b1000, 1, 1);
        idle();
        drain();

        // Hold backs up the queue: four accepted, fifth waits
        i_hold = 1'b1;
        send(mk(3'd1, 2'd0, 2'd0, 8'h11), 8'h11, 4'b0000, 1, 0);
        send(mk(3'd1, 2'd1, 2'd0, 8'h22), 8'h22, 4'b0000, 1, 0);
        send(mk(3'd1, 2'd2, 2'd0, 8'h33), 8'h33, 4'b0000, 1, 0);
        send(mk(3'd2, 2'd0, 2'd1, 8'h00), 8'h33, 4'b0000, 1, 0);
        chk("full_ready_low", 32'(o_ready), 32'd0);
        i_inst  = mk(3'd6, 2'd2, 2'd0, 8'h00);
        i_valid = 1'b1;
        repeat (3) begin
            @(posedge i_clk); #1;
        end
        chk("held_ready_low", 32'(o_ready), 32'd0);
        chk("held_busy", 32'(o_busy), 32'd1);
        i_hold = 1'b0;
        @(posedge i_clk); #1;
        chk("ready_after_pop", 32'(o_ready), 32'd1);
        send(mk(3'd6, 2'd2, 2'd0, 8'h00), 8'h00, 4'b1000, 1, 0);
        send(mk(3'd5, 2'd1, 2'd2, 8'h00), 8'h22, 4'b0000, 1, 0);
        send(mk(3'd4, 2'd0, 2'd1, 8'h00), 8'h22, 4'b0000, 1, 0);
        idle();
        drain();

        // NOP produces no pulse and leaves outputs untouched
        send(mk(3'd1, 2'd1, 2'd0, 8'hAA), 8'hAA, 4'b0100, 1, 1);
        send(mk(3'd0, 2'd1, 2'd1, 8'h5C), 8'h00, 4'b0000, 0, 0);
        idle();
        drain();
        repeat (2) @(posedge i_clk);
        #1;
        chk("nop_hold_data", 32'(o_data), 32'hAA);
        chk("nop_hold_flag", 32'(o_flag), 32'b0100);
        send(mk(3'd7, 2'd0, 2'd1, 8'h00), 8'hAA, 4'b0100, 1, 1);
        idle();
        drain();

        // Asynchronous reset with queued work discards everything
        i_hold = 1'b1;
        send(mk(3'd1, 2'd0, 2'd0, 8'h99), 8'h00, 4'b0000, 0, 0);
        send(mk(3'd1, 2'd1, 2'd0, 8'h98), 8'h00, 4'b0000, 0, 0);
        send(mk(3'd7, 2'd0, 2'd0, 8'h00), 8'h00, 4'b0000, 0, 0);
        idle();
        chk("pre_rst_busy", 32'(o_busy), 32'd1);
        #2;
        i_rsn = 1'b0;
        #1;
        chk("mid_rst_res_valid", 32'(o_res_valid), 32'd0);
        chk("mid_rst_data", 32'(o_data), 32'd0);
        chk("mid_rst_flag", 32'(o_flag), 32'd0);
        chk("mid_rst_ready", 32'(o_ready), 32'd1);
        chk("mid_rst_busy", 32'(o_busy), 32'd0);
        i_hold = 1'b0;
        @(negedge i_clk);
        i_rsn = 1'b1;
        @(posedge i_clk); #1;
        send(mk(3'd7, 2'd0, 2'd0, 8'h00), 8'h00, 4'b1000, 1, 1);
        idle();
        drain();

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
